bsg_mem_1rw_sync_arb: RTL

//  Shares one single-port synchronous RAM (1 access/cycle, read data valid the cycle after issue,
//  not held) among num_req_p requesters. Round-robin grants, optional zero-fill of the RAM after

---
 rtl/bsg_mem_1rw_sync_arb_pkg.sv | 12 +
 rtl/bsg_mem_1rw_sync_arb_resp_fifo.sv | 51 +++++
 rtl/bsg_mem_1rw_sync_arb.sv | 132 +++++++++++++
 3 files changed

// File: rtl/bsg_mem_1rw_sync_arb_pkg.sv
// bsg_mem_1rw_sync_arb_pkg: shared types and constants for the 1rw RAM arbiter
//   state_e          controller states (reset hold, RAM clear, normal operation)
//   credit_width_lp  width of the response-buffer credit counter
//   credits_max_lp   response-buffer depth, i.e. the number of reads that may be outstanding
package bsg_mem_1rw_sync_arb_pkg;

    typedef enum logic [1:0] {eRESET, eCLEAR, eREADY} state_e;

    localparam int credit_width_lp = 2;
    localparam logic [credit_width_lp-1:0] credits_max_lp = 2'd2;

endpackage

// File: rtl/bsg_mem_1rw_sync_arb_resp_fifo.sv
// bsg_mem_1rw_sync_arb_resp_fifo: 2-entry FIFO holding {id,data} read responses
//   clk_i, reset_n_i     clock, asynchronous active-low reset
//   v_i, data_i, ready_o  enqueue side (valid/ready)
//   v_o, data_o, yumi_i   dequeue side (valid/yumi, yumi only while v_o)
module bsg_mem_1rw_sync_arb_resp_fifo #(
    parameter int width_p = 32
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    output logic               ready_o,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);

    logic [width_p-1:0] mem_q [2];
    logic [width_p-1:0] mem_d [2];
    logic               wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [1:0]         count_q, count_d;
    logic               push, pop;

    always_comb begin
        ready_o  = count_q != 2'd2;
        v_o      = count_q != 2'd0;
        data_o   = mem_q[rd_ptr_q];
        push     = v_i & ready_o;
        pop      = yumi_i & v_o;
        mem_d    = mem_q;
        if (push) mem_d[wr_ptr_q] = data_i;
        wr_ptr_d = wr_ptr_q ^ push;
        rd_ptr_d = rd_ptr_q ^ pop;
        count_d  = count_q + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/bsg_mem_1rw_sync_arb.sv
// bsg_mem_1rw_sync_arb: round-robin sharing of one 1rw synchronous RAM among num_req_p requesters
//   clk_i, reset_n_i                 clock, asynchronous active-low reset
//   v_i, w_i, addr_i, data_i         per-requester request (valid, write, address, write data)
//   ready_and_o                      one-hot grant, request accepted when v_i & ready_and_o
//   mem_v_o/w_o/addr_o/data_o        RAM command, issued in the grant cycle
//   mem_data_i                       RAM read data, valid the cycle after a read issue
//   resp_v_o/id_o/data_o, resp_yumi_i read responses in grant order
//   init_done_o                      high once requests are accepted (after optional zero-fill)
module bsg_mem_1rw_sync_arb
    import bsg_mem_1rw_sync_arb_pkg::*;
#(
    parameter  int num_req_p        = 2,
    parameter  int width_p          = 32,
    parameter  int els_p            = 64,
    parameter  int clear_on_reset_p = 1,
    localparam int addr_width_lp    = (els_p > 1) ? $clog2(els_p) : 1,
    localparam int id_width_lp      = (num_req_p > 1) ? $clog2(num_req_p) : 1
) (
    input  logic                           clk_i,
    input  logic                           reset_n_i,
    input  logic [num_req_p-1:0]           v_i,
    input  logic [num_req_p-1:0]           w_i,
    input  logic [num_req_p*addr_width_lp-1:0] addr_i,
    input  logic [num_req_p*width_p-1:0]   data_i,
    output logic [num_req_p-1:0]           ready_and_o,
    output logic                           mem_v_o,
    output logic                           mem_w_o,
    output logic [addr_width_lp-1:0]       mem_addr_o,
    output logic [width_p-1:0]             mem_data_o,
    input  logic [width_p-1:0]             mem_data_i,
    output logic                           resp_v_o,
    output logic [id_width_lp-1:0]         resp_id_o,
    output logic [width_p-1:0]             resp_data_o,
    input  logic                           resp_yumi_i,
    output logic                           init_done_o
);

    // (base + k) mod num_req_p for base < num_req_p and k < num_req_p
    function automatic logic [id_width_lp-1:0] wrap_idx(input int base, input int k);
        int s;
        s = base + k;
        return id_width_lp'(s >= num_req_p ? s - num_req_p : s);
    endfunction

    state_e                     state_q, state_d;
    logic [addr_width_lp-1:0]   clr_cnt_q, clr_cnt_d;
    logic [id_width_lp-1:0]     rr_q, rr_d;
    logic [credit_width_lp-1:0] credits_q, credits_d;
    logic                       rd_inflight_q, rd_inflight_d;
    logic [id_width_lp-1:0]     rd_id_q, rd_id_d;

    logic [num_req_p-1:0]       elig;
    logic                       grant_v, rd_grant, clr, fifo_ready;
    logic [id_width_lp-1:0]     grant_id;

    always_comb begin
        clr      = state_q == eCLEAR;
        elig     = '0;
        grant_v  = 1'b0;
        grant_id = '0;
        // Reads need a free response-buffer slot; writes never do.
        for (int i = 0; i < num_req_p; i++)
            elig[i] = (state_q == eREADY) & v_i[i] & (w_i[i] | (credits_q != '0));
        // First eligible requester at or after the round-robin pointer.
        for (int k = 0; k < num_req_p; k++)
            if (!grant_v && elig[wrap_idx(int'(rr_q), k)]) begin
                grant_v  = 1'b1;
                grant_id = wrap_idx(int'(rr_q), k);
            end
        rd_grant    = grant_v & ~w_i[grant_id];
        ready_and_o = grant_v ? num_req_p'(1) << grant_id : '0;
        mem_v_o     = clr | grant_v;
        mem_w_o     = clr | (grant_v & w_i[grant_id]);
        mem_addr_o  = clr ? clr_cnt_q
                    : grant_v ? addr_i[int'(grant_id)*addr_width_lp +: addr_width_lp] : '0;
        mem_data_o  = grant_v ? data_i[int'(grant_id)*width_p +: width_p] : '0;
        init_done_o = state_q == eREADY;

        state_d       = (state_q == eRESET) ? ((clear_on_reset_p != 0) ? eCLEAR : eREADY)
                      : (clr && clr_cnt_q == addr_width_lp'(els_p - 1)) ? eREADY : state_q;
        clr_cnt_d     = clr ? clr_cnt_q + addr_width_lp'(1) : clr_cnt_q;
        rr_d          = grant_v ? wrap_idx(int'(grant_id), 1) : rr_q;
        credits_d     = credits_q - credit_width_lp'(rd_grant) + credit_width_lp'(resp_yumi_i);
        rd_inflight_d = rd_grant;
        rd_id_d       = rd_grant ? grant_id : rd_id_q;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q       <= eRESET;
            clr_cnt_q     <= '0;
            rr_q          <= '0;
            credits_q     <= credits_max_lp;
            rd_inflight_q <= 1'b0;
            rd_id_q       <= '0;
        end else begin
            state_q       <= state_d;
            clr_cnt_q     <= clr_cnt_d;
            rr_q          <= rr_d;
            credits_q     <= credits_d;
            rd_inflight_q <= rd_inflight_d;
            rd_id_q       <= rd_id_d;
        end
    end

    // RAM data is only valid in the cycle after issue, so it is captured unconditionally;
    // the credit counter guarantees a free slot.
    bsg_mem_1rw_sync_arb_resp_fifo #(.width_p(id_width_lp + width_p)) resp_fifo (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .v_i       (rd_inflight_q),
        .data_i    ({rd_id_q, mem_data_i}),
        .ready_o   (fifo_ready),
        .v_o       (resp_v_o),
        .data_o    ({resp_id_o, resp_data_o}),
        .yumi_i    (resp_yumi_i)
    );

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (reset_n_i) begin
            assert (!(resp_yumi_i && !resp_v_o)) else $error("resp_yumi_i without resp_v_o");
            assert (credits_q <= credits_max_lp) else $error("credit count out of range");
            assert (!rd_inflight_q || fifo_ready) else $error("response buffer overflow");
            for (int i = 0; i < num_req_p; i++)
                assert (!v_i[i] || int'(addr_i[i*addr_width_lp +: addr_width_lp]) < els_p)
                    else $error("request address out of range");
        end
    end
`endif

endmodule
